// File: rtl/dice_tile_router_gen.sv
// dice_tile_router_gen
// Full crossbar for one DICE tile. It routes the N/E/S/W track inputs and the
// PE-local inputs to the N/E/S/W track outputs and the PE-local outputs.
// Each output has its own select field. Each output can run combinationally, or
// through a 1-cycle register whose load is gated by overload control.
// The routing config is streamed into a shadow register one CFG_CHUNK beat at
// a time. A commit swaps it into the active config atomically, so the live
// route never carries a partially loaded config.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   in_data       NUM_IN words: N[0..T-1], E, S, W, then L[0..LOCAL_IN-1]
//   out_data      NUM_OUT words: N, E, S, W, then L[0..LOCAL_OUT-1]
//   ovl_ctrl      per-output load enable for registered outputs with ovl_en
//   cfg_in_valid  config beat valid
//   cfg_in_data   config beat (CFG_CHUNK bits)
//   cfg_in_ready  loader can accept a beat (registered state decode)
//   cfg_commit    swap shadow into active (only honoured when full)
//   cfg_clear     discard shadow, loader back to empty (wins over beat/commit)
//   cfg_full      shadow holds all BEATS beats (registered state decode)
module dice_tile_router_gen #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TRACKS    = 2,
  parameter int unsigned LOCAL_IN  = 2,
  parameter int unsigned LOCAL_OUT = 4,
  parameter int unsigned CFG_CHUNK = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [(4*TRACKS+LOCAL_IN)*DATA_W-1:0]  in_data,
  output logic [(4*TRACKS+LOCAL_OUT)*DATA_W-1:0] out_data,
  input  logic [4*TRACKS+LOCAL_OUT-1:0]          ovl_ctrl,
  input  logic                                   cfg_in_valid,
  input  logic [CFG_CHUNK-1:0]                   cfg_in_data,
  output logic                                   cfg_in_ready,
  input  logic                                   cfg_commit,
  input  logic                                   cfg_clear,
  output logic                                   cfg_full
);

  localparam int unsigned NUM_IN   = 4*TRACKS + LOCAL_IN;
  localparam int unsigned NUM_OUT  = 4*TRACKS + LOCAL_OUT;
  localparam int unsigned SEL_W    = $clog2(NUM_IN + 1);
  localparam int unsigned FIELD_W  = SEL_W + 2;
  localparam int unsigned CFG_W    = NUM_OUT * FIELD_W;
  localparam int unsigned BEATS    = (CFG_W + CFG_CHUNK - 1) / CFG_CHUNK;
  localparam int unsigned SHADOW_W = BEATS * CFG_CHUNK;
  localparam int unsigned CNT_W    = $clog2(BEATS + 1);

  // Reset config: every output selects the all-zero source, combinational.
  function automatic logic [CFG_W-1:0] reset_cfg();
    logic [CFG_W-1:0] c;
    c = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      c[o*FIELD_W +: SEL_W] = SEL_W'(NUM_IN);
    end
    return c;
  endfunction

  localparam logic [CFG_W-1:0] RST_CFG = reset_cfg();

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } ld_state_t;

  ld_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [SHADOW_W-1:0]   shadow;
  logic [CFG_W-1:0]      active;
  logic                  commit_fire;

  logic [NUM_OUT-1:0][DATA_W-1:0] out_q;
  logic [NUM_OUT-1:0][DATA_W-1:0] sel_data;
  logic [NUM_OUT-1:0]             reg_mode;
  logic [NUM_OUT-1:0]             ovl_en;

  // A commit lands only from FULL, and only when clear and reset are both idle.
  assign commit_fire = (state == ST_FULL) && cfg_commit && !cfg_clear && !rst;

  // Loader FSM. Ready and full are registered alongside the state so they
  // never depend combinationally on cfg_in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      cnt          <= '0;
      shadow       <= '0;
      active       <= RST_CFG;
      cfg_in_ready <= 1'b1;
      cfg_full     <= 1'b0;
    end else if (cfg_clear) begin
      state        <= ST_EMPTY;
      cnt          <= '0;
      cfg_in_ready <= 1'b1;
      cfg_full     <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY, ST_LOADING: begin
          if (cfg_in_valid) begin
            // New beat enters at the top, so beat 0 ends up at the LSBs.
            shadow <= {cfg_in_data, shadow[SHADOW_W-1:CFG_CHUNK]};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(BEATS - 1)) begin
              state        <= ST_FULL;
              cfg_in_ready <= 1'b0;
              cfg_full     <= 1'b1;
            end else begin
              state <= ST_LOADING;
            end
          end
        end
        ST_FULL: begin
          if (cfg_commit) begin
            active       <= shadow[CFG_W-1:0];
            state        <= ST_EMPTY;
            cnt          <= '0;
            cfg_in_ready <= 1'b1;
            cfg_full     <= 1'b0;
          end
        end
        default: begin
          state        <= ST_EMPTY;
          cnt          <= '0;
          cfg_in_ready <= 1'b1;
          cfg_full     <= 1'b0;
        end
      endcase
    end
  end

  // Crossbar: decode each output's field and pick its source. Out-of-range
  // selects fall through to zero.
  always_comb begin
    sel_data = '0;
    reg_mode = '0;
    ovl_en   = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      reg_mode[o] = active[o*FIELD_W + SEL_W];
      ovl_en[o]   = active[o*FIELD_W + SEL_W + 1];
      for (int i = 0; i < int'(NUM_IN); i++) begin
        if (active[o*FIELD_W +: SEL_W] == SEL_W'(i)) begin
          sel_data[o] = in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Output registers. They are cleared on commit so registered outputs never
  // show data selected under the old config after the swap.
  always_ff @(posedge clk) begin
    if (rst || commit_fire) begin
      out_q <= '0;
    end else begin
      for (int o = 0; o < int'(NUM_OUT); o++) begin
        if (!(reg_mode[o] && ovl_en[o] && !ovl_ctrl[o])) begin
          out_q[o] <= sel_data[o];
        end
      end
    end
  end

  // Output mux: combinational outputs bypass the register entirely.
  always_comb begin
    out_data = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      out_data[o*DATA_W +: DATA_W] = reg_mode[o] ? out_q[o] : sel_data[o];
    end
  end

endmodule

// File: doc/dice_tile_router_gen.md
# dice_tile_router_gen

Parametrised next-generation DICE tile data router: a full crossbar from N/E/S/W track inputs plus PE-local inputs to N/E/S/W track outputs plus PE-local outputs.
- Per output: a selectable registered (1-cycle) or combinational mode, and overload-gated hold.
- Configuration is streamed in through a double-buffered loader and swapped atomically by a commit pulse, so a tile can be reconfigured without glitching the active route.
- Sits inside a DICE tile between the neighbouring tiles and the PE; one instance for 32-bit data, one for 1-bit predicates (DATA_W=1).

## Interface
Parameters:
- DATA_W, 32, bits per track
- TRACKS, 2, tracks per side (N/E/S/W)
- LOCAL_IN, 2, PE outputs fed into the router
- LOCAL_OUT, 4, router outputs fed to the PE
- CFG_CHUNK, 16, config bits per load beat

Derived (localparam, not overridable):
- NUM_IN = 4*TRACKS+LOCAL_IN (10)
- NUM_OUT = 4*TRACKS+LOCAL_OUT (12)
- SEL_W = $clog2(NUM_IN+1) (4)
- CFG_W = NUM_OUT*(SEL_W+2) (72)
- BEATS = ceil(CFG_W/CFG_CHUNK) (5)

Ports:
- clk  in  1  sole clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_IN*DATA_W  inputs, index order N[0..T-1], E, S, W, then L[0..LOCAL_IN-1]
- out_data  out  NUM_OUT*DATA_W  outputs, same side order, then L[0..LOCAL_OUT-1]
- ovl_ctrl  in  NUM_OUT  per-output overload control (load enable)
- cfg_in_valid  in  1  config beat valid
- cfg_in_data  in  CFG_CHUNK  config beat
- cfg_in_ready  out  1  loader can accept a beat
- cfg_commit  in  1  swap shadow config into active
- cfg_clear  in  1  discard partial/complete shadow config
- cfg_full  out  1  shadow holds BEATS beats, awaiting commit

## Operation
Per-output config field o, at base b=o*(SEL_W+2):
- sel = [b+SEL_W-1:b]
- reg_mode = bit b+SEL_W
- ovl_en = bit b+SEL_W+1

Output selection:
- sel < NUM_IN: output selects in_data[sel].
- sel >= NUM_IN: output selects all-zero.

Per-output path:
- reg_mode=0: out = selected input, combinational; ovl_en ignored.
- reg_mode=1: register out_q[o] loads selected input each cycle, except when ovl_en=1 and ovl_ctrl[o]=0, in which case it holds. out = out_q[o].

Loader FSM, with beat counter cnt:
- EMPTY: cnt=0, ready=1.
- LOADING: 0<cnt<BEATS, ready=1.
- FULL: cnt=BEATS, ready=0, cfg_full=1.

Beat acceptance:
- Accepted when cfg_in_valid && cfg_in_ready.
- Shadow (BEATS*CFG_CHUNK bits) shifts right by CFG_CHUNK; the new beat enters the top chunk, so beat 0 ends at LSBs.
- Beats past BEATS never accepted.
- Padding bits above CFG_W are discarded at commit.

Transitions:
- EMPTY→LOADING on first beat; LOADING→FULL on BEATS-th beat.
- FULL→EMPTY on cfg_commit: active ← shadow[CFG_W-1:0]; all out_q cleared to 0 in the same edge.
- cfg_commit outside FULL: ignored.
- cfg_clear in any state: →EMPTY, cnt=0, no commit. Clear wins over a simultaneous beat or commit.

Reset:
- Active config = every sel=NUM_IN, reg_mode=0, ovl_en=0, so all out_data=0.
- out_q=0, loader EMPTY.
- cfg_in_ready=1, cfg_full=0.
- Shadow contents don't-care.
- Reset mid-load or in FULL discards the shadow; the active config returns to its reset value.

## Timing
- Combinational outputs: zero latency from in_data/active config.
- Registered outputs: 1 cycle latency.
- New config effective the cycle after the commit edge: combinational outputs change then; registered outputs show 0 that cycle, then data selected under the new config one cycle later.
- A beat offered on the last cycle before FULL is accepted; from the next cycle cfg_in_ready=0.
- cfg_in_ready and cfg_full are registered state decodes only, with no combinational path from cfg_in_valid.
- Minimum reconfiguration: BEATS beat cycles + 1 commit cycle; a new load may begin the cycle after commit.
- cfg_commit on the same edge as the final beat: ignored (state not yet FULL).

## Test plan
- Reset, then apply in_data all 0xFFFFFFFF → every out_data=0; cfg_in_ready=1, cfg_full=0.
- Load 5 beats routing out N0←in W1 (sel=7) combinational and out L0←in N0 (sel=0) registered; commit. Drive in_data W1=0xA5A5A5A5, N0=0x12345678 → N0 output=0xA5A5A5A5 same cycle; L0 output=0 the cycle after commit, then 0x12345678 one cycle after in_data applied.
- Registered output with ovl_en=1: ovl_ctrl=1 with input 0x11, then ovl_ctrl=0 with input 0x22 for 3 cycles → output stays 0x11; ovl_ctrl=1 → output 0x22 next cycle.
- Load 5 beats with no commit, hold cfg_in_valid=1 with a 6th beat → beat refused (ready=0), cfg_full=1, active routing unchanged; commit asserted with cfg_clear in the same cycle → EMPTY, active unchanged.
- cfg_clear after 3 beats, then full 5-beat load and commit → config equals only the last 5 beats.
- sel=15 (>NUM_IN) on any output → output 0; assert rst in LOADING → outputs 0, EMPTY next cycle.
